// File: rtl/masked_aes_pkg.sv
// Shared constants, FSM state type and 4-bit S-box for the masked AES datapath.
package masked_aes_pkg;

  localparam int unsigned W     = 4;
  localparam int unsigned NX    = 4;
  localparam int unsigned Depth = 16;

  typedef enum logic [1:0] {StIdle, StAdj, StRef, StAddr} state_e;

  function automatic logic [W-1:0] sbox4(input logic [W-1:0] a);
    logic [W-1:0] s;
    unique case (a)
      4'h0: s = 4'hC;
      4'h1: s = 4'h5;
      4'h2: s = 4'h6;
      4'h3: s = 4'hB;
      4'h4: s = 4'h9;
      4'h5: s = 4'h0;
      4'h6: s = 4'hA;
      4'h7: s = 4'hD;
      4'h8: s = 4'h3;
      4'h9: s = 4'hE;
      4'hA: s = 4'hF;
      4'hB: s = 4'h8;
      4'hC: s = 4'h4;
      4'hD: s = 4'h7;
      4'hE: s = 4'h1;
      default: s = 4'h2;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/table_permute.sv
// Combinational table shift: entry a of the result is entry (a ^ off_i) of the input.
module table_permute
  import masked_aes_pkg::*;
(
  input  logic [Depth-1:0][W-1:0] tbl_i,
  input  logic [W-1:0]            off_i,
  output logic [Depth-1:0][W-1:0] tbl_o
);

  always_comb begin
    tbl_o = '0;
    for (int a = 0; a < Depth; a++) begin
      tbl_o[a] = tbl_i[W'(a) ^ off_i];
    end
  end

endmodule

// File: rtl/masked_table_responder.sv
// Table-recomputation masked S-box: 4 input shares in, 5 output shares out,
// sequenced by load/adjust/refresh/address strobes from the AES controller.
module masked_table_responder
  import masked_aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         divide_en,
  input  logic         adjust_en,
  input  logic [2:0]   adjust_en1,
  input  logic         refresh_en,
  input  logic         address_en,
  input  logic [W-1:0] x0,
  input  logic [W-1:0] x1,
  input  logic [W-1:0] x2,
  input  logic [W-1:0] x3,
  input  logic [W-1:0] rnd,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [W-1:0] y4,
  output logic         y_valid,
  output logic         err
);

  state_e                  state_q, state_d;
  logic [1:0]              k_q, k_d;
  logic                    loaded_q, loaded_d;
  logic [Depth-1:0][W-1:0] tbl_q, tbl_d, tbl_perm;
  logic [NX-1:0][W-1:0]    xs_q, xs_d;
  logic [W-1:0]            acc_q, acc_d, r2_q, r2_d, r3_q, r3_d, r4_q, r4_d;
  logic [W-1:0]            y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d, y4_q, y4_d;
  logic                    y_valid_q, y_valid_d, err_q, err_d;
  logic [1:0]              perm_idx;

  // The adjust that leaves IDLE is always adjust 0, whatever k holds.
  assign perm_idx = (state_q == StIdle) ? 2'd0 : k_q;

  table_permute u_permute (
    .tbl_i (tbl_q),
    .off_i (xs_q[perm_idx]),
    .tbl_o (tbl_perm)
  );

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    loaded_d  = loaded_q;
    tbl_d     = tbl_q;
    xs_d      = xs_q;
    acc_d     = acc_q;
    r2_d      = r2_q;
    r3_d      = r3_q;
    r4_d      = r4_q;
    y0_d      = y0_q;
    y1_d      = y1_q;
    y2_d      = y2_q;
    y3_d      = y3_q;
    y4_d      = y4_q;
    y_valid_d = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (adjust_en && refresh_en) begin
          err_d = 1'b1;
        end else if (adjust_en) begin
          if (!loaded_q || adjust_en1 != 3'd0) begin
            err_d = 1'b1;
          end else begin
            tbl_d   = tbl_perm;
            k_d     = 2'd0;
            state_d = StRef;
          end
        end else if (refresh_en) begin
          err_d = 1'b1;
        end else if (divide_en) begin
          for (int a = 0; a < Depth; a++) begin
            tbl_d[a] = sbox4(W'(a)) ^ rnd;
          end
          acc_d    = rnd;
          xs_d     = {x3, x2, x1, x0};
          k_d      = 2'd0;
          loaded_d = 1'b1;
        end
      end
      StAdj: begin
        if (refresh_en || (adjust_en && adjust_en1 != {1'b0, k_q})) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (adjust_en) begin
          tbl_d   = tbl_perm;
          state_d = StRef;
        end
      end
      StRef: begin
        if (adjust_en) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (refresh_en) begin
          for (int a = 0; a < Depth; a++) begin
            tbl_d[a] = tbl_q[a] ^ rnd;
          end
          case (k_q)
            2'd0:    acc_d = acc_q ^ rnd;
            2'd1:    r2_d  = rnd;
            2'd2:    r3_d  = rnd;
            default: r4_d  = rnd;
          endcase
          if (k_q == 2'd3) begin
            state_d = StAddr;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = StAdj;
          end
        end
      end
      StAddr: begin
        if (adjust_en || refresh_en) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (address_en) begin
          y0_d      = tbl_q[0];
          y1_d      = acc_q;
          y2_d      = r2_q;
          y3_d      = r3_q;
          y4_d      = r4_q;
          y_valid_d = 1'b1;
          loaded_d  = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      k_q       <= 2'd0;
      loaded_q  <= 1'b0;
      tbl_q     <= '0;
      xs_q      <= '0;
      acc_q     <= '0;
      r2_q      <= '0;
      r3_q      <= '0;
      r4_q      <= '0;
      y0_q      <= '0;
      y1_q      <= '0;
      y2_q      <= '0;
      y3_q      <= '0;
      y4_q      <= '0;
      y_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      loaded_q  <= loaded_d;
      tbl_q     <= tbl_d;
      xs_q      <= xs_d;
      acc_q     <= acc_d;
      r2_q      <= r2_d;
      r3_q      <= r3_d;
      r4_q      <= r4_d;
      y0_q      <= y0_d;
      y1_q      <= y1_d;
      y2_q      <= y2_d;
      y3_q      <= y3_d;
      y4_q      <= y4_d;
      y_valid_q <= y_valid_d;
      err_q     <= err_d;
    end
  end

  assign y0      = y0_q;
  assign y1      = y1_q;
  assign y2      = y2_q;
  assign y3      = y3_q;
  assign y4      = y4_q;
  assign y_valid = y_valid_q;
  assign err     = err_q;

endmodule

// File: tb/tb_masked_table_responder.sv
// Directed bench for masked_table_responder: nominal, masked, back-to-back,
// protocol errors, mid-round reset and strobe gaps.
module tb_masked_table_responder;
  import masked_aes_pkg::*;

  logic         clk, rst;
  logic         divide_en, adjust_en, refresh_en, address_en;
  logic [2:0]   adjust_en1;
  logic [3:0]   x0, x1, x2, x3, rnd;
  logic [3:0]   y0, y1, y2, y3, y4;
  logic         y_valid, err;

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  bit hold_b = 1'b0;

  masked_table_responder dut (
    .clk        (clk),
    .rst        (rst),
    .divide_en  (divide_en),
    .adjust_en  (adjust_en),
    .adjust_en1 (adjust_en1),
    .refresh_en (refresh_en),
    .address_en (address_en),
    .x0         (x0),
    .x1         (x1),
    .x2         (x2),
    .x3         (x3),
    .rnd        (rnd),
    .y0         (y0),
    .y1         (y1),
    .y2         (y2),
    .y3         (y3),
    .y4         (y4),
    .y_valid    (y_valid),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (y_valid === 1'b1) vcount <= vcount + 1;

  // One strobe cycle, then optional idle gap; outputs are sampled 1 time unit after the edge.
  task automatic cyc(input bit de, input bit ae, input logic [2:0] a1, input bit re,
                     input bit ad, input logic [3:0] r, input int gap);
    divide_en  = de | hold_b;
    adjust_en  = ae;
    adjust_en1 = a1;
    refresh_en = re;
    address_en = ad | hold_b;
    rnd        = r;
    @(posedge clk); #1;
    divide_en  = hold_b;
    adjust_en  = 1'b0;
    adjust_en1 = 3'd0;
    refresh_en = 1'b0;
    address_en = hold_b;
    rnd        = 4'h0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic round(input logic [3:0] xa, xb, xc, xd, r0, r1, r2, r3, r4, input int gap);
    x0 = xa; x1 = xb; x2 = xc; x3 = xd;
    cyc(1, 0, 3'd0, 0, 0, r0, gap);
    cyc(0, 1, 3'd0, 0, 0, 4'h0, gap);
    cyc(0, 0, 3'd0, 1, 0, r1, gap);
    cyc(0, 1, 3'd1, 0, 0, 4'h0, gap);
    cyc(0, 0, 3'd0, 1, 0, r2, gap);
    cyc(0, 1, 3'd2, 0, 0, 4'h0, gap);
    cyc(0, 0, 3'd0, 1, 0, r3, gap);
    cyc(0, 1, 3'd3, 0, 0, 4'h0, gap);
    cyc(0, 0, 3'd0, 1, 0, r4, gap);
    cyc(0, 0, 3'd0, 0, 1, 4'h0, 0);
  endtask

  task automatic test_reset();
    logic [3:0] got [5];
    rst = 1'b1;
    divide_en = 0; adjust_en = 0; adjust_en1 = 0; refresh_en = 0; address_en = 0;
    x0 = 0; x1 = 0; x2 = 0; x3 = 0; rnd = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    got = '{y0, y1, y2, y3, y4};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] !== 4'h0) begin
        errors++; $display("FAIL reset y%0d got %h want 0", i, got[i]);
      end
    end
    checks++;
    if (y_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset flags got v=%b e=%b want 0 0", y_valid, err);
    end
  endtask

  task automatic test_idle_err();
    cyc(0, 0, 3'd0, 1, 0, 4'h0, 0);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL idle_refresh err got %b want 1", err);
    end
    cyc(0, 1, 3'd0, 0, 0, 4'h0, 0);
    checks++;
    if (err !== 1'b1 || dut.state_q !== StIdle) begin
      errors++; $display("FAIL idle_adjust err=%b state=%0d want 1 idle", err, dut.state_q);
    end
    cyc(0, 0, 3'd0, 0, 0, 4'h0, 0);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL idle_err_pulse err got %b want 0", err);
    end
  endtask

  task automatic test_nominal();
    logic [3:0] got [5];
    logic [3:0] exp [5];
    exp = '{4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
    round(4'h1, 4'h2, 4'h4, 4'h8, 0, 0, 0, 0, 0, 0);
    checks++;
    if (y_valid !== 1'b1) begin
      errors++; $display("FAIL nominal y_valid got %b want 1", y_valid);
    end
    got = '{y0, y1, y2, y3, y4};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++; $display("FAIL nominal y%0d got %h want %h", i, got[i], exp[i]);
      end
    end
    cyc(0, 0, 3'd0, 0, 0, 4'h0, 0);
    checks++;
    if (y_valid !== 1'b0) begin
      errors++; $display("FAIL nominal pulse y_valid got %b want 0", y_valid);
    end
  endtask

  task automatic test_masked(input string name, input int gap);
    logic [3:0] got [5];
    logic [3:0] exp [5];
    int base;
    exp = '{4'h1, 4'h6, 4'h6, 4'h9, 4'hA};
    base = vcount;
    round(4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h6, 4'h9, 4'hA, gap);
    checks++;
    if (y_valid !== 1'b1) begin
      errors++; $display("FAIL %s y_valid got %b want 1", name, y_valid);
    end
    got = '{y0, y1, y2, y3, y4};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++; $display("FAIL %s y%0d got %h want %h", name, i, got[i], exp[i]);
      end
    end
    checks++;
    if ((y0 ^ y1 ^ y2 ^ y3 ^ y4) !== 4'h2) begin
      errors++; $display("FAIL %s xor got %h want 2", name, y0 ^ y1 ^ y2 ^ y3 ^ y4);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (vcount - base !== 1) begin
      errors++; $display("FAIL %s pulses got %0d want 1", name, vcount - base);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = vcount;
    hold_b = 1'b1;
    round(4'h1, 4'h2, 4'h4, 4'h8, 0, 0, 0, 0, 0, 0);
    checks++;
    if (y_valid !== 1'b1 || y0 !== 4'h2) begin
      errors++; $display("FAIL b2b_first v=%b y0=%h want 1 2", y_valid, y0);
    end
    round(4'h0, 4'h0, 4'h0, 4'h3, 0, 0, 0, 0, 0, 0);
    checks++;
    if (y_valid !== 1'b1 || y0 !== 4'hB || y1 !== 4'h0) begin
      errors++; $display("FAIL b2b_second v=%b y0=%h y1=%h want 1 b 0", y_valid, y0, y1);
    end
    repeat (5) @(posedge clk);
    #1;
    hold_b = 1'b0;
    divide_en = 1'b0;
    address_en = 1'b0;
    checks++;
    if (vcount - base !== 2) begin
      errors++; $display("FAIL b2b_pulses got %0d want 2", vcount - base);
    end
    checks++;
    if (y0 !== 4'hB) begin
      errors++; $display("FAIL b2b_hold y0 got %h want b", y0);
    end
  endtask

  task automatic test_protocol_error();
    int base;
    base = vcount;
    x0 = 4'h1; x1 = 4'h2; x2 = 4'h4; x3 = 4'h8;
    cyc(1, 0, 3'd0, 0, 0, 4'h3, 0);
    cyc(0, 1, 3'd2, 0, 0, 4'h0, 0);
    checks++;
    if (err !== 1'b1 || y_valid !== 1'b0 || dut.state_q !== StIdle) begin
      errors++;
      $display("FAIL proto_err err=%b v=%b state=%0d want 1 0 idle", err, y_valid, dut.state_q);
    end
    cyc(0, 0, 3'd0, 0, 0, 4'h0, 2);
    checks++;
    if (err !== 1'b0 || vcount != base) begin
      errors++; $display("FAIL proto_after err=%b pulses=%0d want 0 0", err, vcount - base);
    end
    test_masked("proto_recover", 0);
  endtask

  task automatic test_collision();
    cyc(1, 0, 3'd0, 0, 0, 4'h0, 0);
    cyc(0, 1, 3'd0, 1, 0, 4'h0, 0);
    checks++;
    if (err !== 1'b1 || dut.state_q !== StIdle) begin
      errors++; $display("FAIL collision err=%b state=%0d want 1 idle", err, dut.state_q);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] got [5];
    int base;
    base = vcount;
    x0 = 4'h1; x1 = 4'h2; x2 = 4'h4; x3 = 4'h8;
    cyc(1, 0, 3'd0, 0, 0, 4'h3, 0);
    cyc(0, 1, 3'd0, 0, 0, 4'h0, 0);
    cyc(0, 0, 3'd0, 1, 0, 4'h5, 0);
    cyc(0, 1, 3'd1, 0, 0, 4'h0, 0);
    cyc(0, 0, 3'd0, 1, 0, 4'h6, 0);
    cyc(0, 1, 3'd2, 0, 0, 4'h0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    got = '{y0, y1, y2, y3, y4};
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (got[i] !== 4'h0) begin
        errors++; $display("FAIL rst_mid y%0d got %h want 0", i, got[i]);
      end
    end
    cyc(0, 0, 3'd2, 1, 1, 4'h9, 3);
    checks++;
    if (vcount != base || y_valid !== 1'b0) begin
      errors++; $display("FAIL rst_mid pulses got %0d want 0", vcount - base);
    end
    test_masked("rst_recover", 0);
  endtask

  initial begin
    test_reset();
    test_idle_err();
    test_nominal();
    test_masked("masked", 0);
    test_back_to_back();
    test_protocol_error();
    test_collision();
    test_reset_mid();
    test_masked("gaps", 3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
